dg0045_key_scan: RTL and testbench

Autonomous 4×4 key-matrix scanner and debouncer that generates the `KIN[3:0]` inputs of the DG0045 core. It drives the matrix columns and synchronises and debounces all 16 keys. Each key's debounced state is then gated by the core's active-low `nL[3:0]` lines, so a core `KTA` reads exactly the keys of the columns it has selected through `ATL`/`SNP`. A one-cycle key event strobe with key code is also provided for external debug or wake logic.

---
 rtl/dg0045_pkg.sv | 15 +
 rtl/dg0045_key_debounce.sv | 45 ++++
 rtl/dg0045_key_scan.sv | 118 +++++++++++
 tb/tb_dg0045_key_scan.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dg0045_pkg.sv
// Shared constants and types for the DG0045 core and its peripherals.
package dg0045_pkg;

    localparam int unsigned KEY_ROWS      = 4;
    localparam int unsigned KEY_COLS      = 4;
    localparam int unsigned NUM_KEYS      = KEY_ROWS * KEY_COLS;
    localparam int unsigned MACHINE_CYCLE = 8;

    // Key index k = 4*col + row, so the packed code is simply k[3:0].
    typedef struct packed {
        logic [1:0] col;
        logic [1:0] row;
    } key_code_t;

endpackage

// File: rtl/dg0045_key_debounce.sv
// Single-key debouncer: flips its stable state after DB_CNT consecutive differing samples
// once the top-level arbiter grants the commit.
module dg0045_key_debounce #(
    parameter int unsigned DB_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic sample,
    input  logic grant,
    output logic ready,
    output logic stable
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_inc;
    logic       stable_q;
    logic       differs;

    always_comb begin
        differs = (sample != stable_q);
        cnt_inc = (cnt_q >= 3'(DB_CNT)) ? 3'(DB_CNT) : cnt_q + 3'd1;
        ready   = sample_en && differs && (cnt_inc == 3'(DB_CNT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 3'd0;
            stable_q <= 1'b0;
        end else if (sample_en) begin
            if (!differs) begin
                cnt_q <= 3'd0;
            end else if (grant) begin
                stable_q <= ~stable_q;
                cnt_q    <= 3'd0;
            end else begin
                // A losing ready key parks at DB_CNT and retries on the next visit.
                cnt_q <= cnt_inc;
            end
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/dg0045_key_scan.sv
// 4x4 key-matrix scanner: drives columns, synchronises and debounces all keys, and
// presents the core-selected columns on KIN along with a key event strobe.
module dg0045_key_scan
    import dg0045_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 64,
    parameter int unsigned DB_CNT   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    input  logic [3:0] nL,
    output logic [3:0] KIN,
    output logic       key_evt,
    output logic [3:0] key_code,
    output logic       key_dn
);

    localparam int unsigned DW = $clog2(SCAN_DIV);

    logic [DW-1:0]       dcnt_q;
    logic [1:0]          col_q;
    logic [3:0]          sync1_q;
    logic [3:0]          sync2_q;
    logic [3:0]          rs;
    logic                scan_tick;
    logic [NUM_KEYS-1:0] ready;
    logic [NUM_KEYS-1:0] grant;
    logic [NUM_KEYS-1:0] stable;
    logic                evt_d;
    key_code_t           code_d;
    logic                dn_d;
    logic [3:0]          kin_d;
    logic [3:0]          kin_q;
    logic                evt_q;
    key_code_t           code_q;
    logic                dn_q;

    assign rs        = ~sync2_q;
    assign scan_tick = (dcnt_q == DW'(SCAN_DIV - 1));

    for (genvar c = 0; c < KEY_COLS; c++) begin : g_col
        for (genvar r = 0; r < KEY_ROWS; r++) begin : g_row
            dg0045_key_debounce #(
                .DB_CNT(DB_CNT)
            ) u_key (
                .clk      (clk),
                .rst      (rst),
                .sample_en(scan_tick && (col_q == 2'(c))),
                .sample   (rs[r]),
                .grant    (grant[c*KEY_ROWS + r]),
                .ready    (ready[c*KEY_ROWS + r]),
                .stable   (stable[c*KEY_ROWS + r])
            );
        end
    end

    // Only the active column can be ready, so the lowest ready index is the lowest row.
    always_comb begin
        grant  = '0;
        evt_d  = 1'b0;
        code_d = '0;
        dn_d   = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (ready[k] && !evt_d) begin
                grant[k] = 1'b1;
                evt_d    = 1'b1;
                code_d   = key_code_t'(4'(k));
                dn_d     = ~stable[k];
            end
        end
    end

    always_comb begin
        kin_d = '0;
        for (int c = 0; c < KEY_COLS; c++) begin
            for (int r = 0; r < KEY_ROWS; r++) begin
                kin_d[r] = kin_d[r] | (stable[c*KEY_ROWS + r] & ~nL[c]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt_q  <= '0;
            col_q   <= 2'd0;
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
            kin_q   <= 4'd0;
            evt_q   <= 1'b0;
            code_q  <= '0;
            dn_q    <= 1'b0;
        end else begin
            sync1_q <= row_n;
            sync2_q <= sync1_q;
            if (scan_tick) begin
                dcnt_q <= '0;
                col_q  <= col_q + 2'd1;
            end else begin
                dcnt_q <= dcnt_q + 1'b1;
            end
            kin_q <= kin_d;
            evt_q <= evt_d;
            if (evt_d) begin
                code_q <= code_d;
                dn_q   <= dn_d;
            end
        end
    end

    assign col_n    = ~(4'b0001 << col_q);
    assign KIN      = kin_q;
    assign key_evt  = evt_q;
    assign key_code = code_q;
    assign key_dn   = dn_q;

endmodule

// File: tb/tb_dg0045_key_scan.sv
// Self-checking bench for dg0045_key_scan: a per-cycle reference model plus directed scenarios.
module tb_dg0045_key_scan;

    localparam int unsigned SD = 8;
    localparam int unsigned DB = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] nL;
    logic [3:0] KIN;
    logic       key_evt;
    logic [3:0] key_code;
    logic       key_dn;

    dg0045_key_scan #(
        .SCAN_DIV(SD),
        .DB_CNT  (DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .row_n   (row_n),
        .col_n   (col_n),
        .nL      (nL),
        .KIN     (KIN),
        .key_evt (key_evt),
        .key_code(key_code),
        .key_dn  (key_dn)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Physical matrix: which keys are held down, plus optional contact noise.
    logic [15:0] keys;
    bit          noise_en;

    // Reference model state.
    int unsigned edge_n;
    logic [15:0] m_stable;
    int          m_cnt[16];
    logic [3:0]  rhist1, rhist2;
    logic [3:0]  exp_kin, exp_code;
    logic        exp_evt, exp_dn;

    // Observed events for the directed scenarios.
    logic [3:0]  evt_codes[$];
    logic        evt_dns[$];
    int          evt_edges[$];

    typedef struct {
        logic [3:0] nl;
        logic [3:0] kin;
    } kin_vec_t;
    kin_vec_t kin_tbl[7];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        edge_n   = 0;
        m_stable = '0;
        for (int k = 0; k < 16; k++) m_cnt[k] = 0;
        rhist1   = 4'h0;
        rhist2   = 4'h0;
        exp_kin  = 4'h0;
        exp_code = 4'h0;
        exp_evt  = 1'b0;
        exp_dn   = 1'b0;
    endtask

    // One clock edge of the reference: rows seen two edges late, one key committed per sample.
    task automatic model_edge();
        int         col;
        logic [3:0] smp;
        bit         won;
        col     = int'((edge_n / SD) % 4);
        smp     = ~rhist2;
        won     = 0;
        exp_kin = 4'h0;
        for (int c = 0; c < 4; c++)
            if (!nL[c])
                for (int r = 0; r < 4; r++) exp_kin[r] = exp_kin[r] | m_stable[4*c + r];
        exp_evt = 1'b0;
        if (edge_n % SD == SD - 1) begin
            for (int r = 0; r < 4; r++) begin
                int k;
                k = 4*col + r;
                if (smp[r] == m_stable[k]) begin
                    m_cnt[k] = 0;
                end else begin
                    if (m_cnt[k] < int'(DB)) m_cnt[k]++;
                    if (m_cnt[k] == int'(DB) && !won) begin
                        won         = 1;
                        m_stable[k] = ~m_stable[k];
                        m_cnt[k]    = 0;
                        exp_evt     = 1'b1;
                        exp_code    = 4'(k);
                        exp_dn      = m_stable[k];
                    end
                end
            end
        end
        rhist2 = rhist1;
        rhist1 = row_n;
        edge_n++;
    endtask

    task automatic drive_rows();
        logic [3:0] r_n;
        int         b;
        r_n = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[4*c + r] && !col_n[c]) r_n[r] = 1'b0;
        if (noise_en && $urandom_range(15) == 0) begin
            b      = int'($urandom_range(3));
            r_n[b] = ~r_n[b];
        end
        row_n = r_n;
    endtask

    task automatic step();
        logic [3:0] exp_col;
        @(posedge clk);
        model_edge();
        #1;
        exp_col = ~(4'b0001 << ((edge_n / SD) % 4));
        chk("col_n", {4'h0, col_n}, {4'h0, exp_col});
        chk("KIN", {4'h0, KIN}, {4'h0, exp_kin});
        chk("key_evt", {7'h0, key_evt}, {7'h0, exp_evt});
        chk("key_code", {4'h0, key_code}, {4'h0, exp_code});
        chk("key_dn", {7'h0, key_dn}, {7'h0, exp_dn});
        if (key_evt) begin
            evt_codes.push_back(key_code);
            evt_dns.push_back(key_dn);
            evt_edges.push_back(int'(edge_n));
        end
        drive_rows();
    endtask

    task automatic clear_events();
        evt_codes.delete();
        evt_dns.delete();
        evt_edges.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_col_n"}, {4'h0, col_n}, 8'h0E);
        chk({tag, "_KIN"}, {4'h0, KIN}, 8'h00);
        chk({tag, "_key_evt"}, {7'h0, key_evt}, 8'h00);
        chk({tag, "_key_code"}, {4'h0, key_code}, 8'h00);
        chk({tag, "_key_dn"}, {7'h0, key_dn}, 8'h00);
    endtask

    // Called #1 after an edge: asserts reset mid-cycle, checks outputs clear at once.
    task automatic apply_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive_rows();
    endtask

    task automatic kin_probe(input string name, input logic [3:0] nl_val, input logic [3:0] exp);
        nL = nl_val;
        repeat (2) step();
        chk(name, {4'h0, KIN}, {4'h0, exp});
    endtask

    initial begin
        rst      = 1'b1;
        row_n    = 4'hF;
        nL       = 4'hF;
        keys     = '0;
        noise_en = 0;
        model_reset();
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_rows();

        // Reset mid-scan, then the column walk is checked every cycle by the model.
        repeat (37) step();
        apply_reset("mid_rst");
        repeat (40) step();

        // Press on key (c=2, r=1).
        clear_events();
        keys[9] = 1'b1;
        repeat (120) step();
        chk("press_evt_count", 8'(evt_codes.size()), 8'd1);
        if (evt_codes.size() >= 1) begin
            chk("press_code", {4'h0, evt_codes[0]}, 8'h09);
            chk("press_dn", {7'h0, evt_dns[0]}, 8'h01);
        end
        kin_probe("press_kin_sel", 4'b1011, 4'b0010);
        kin_probe("press_kin_none", 4'b1111, 4'b0000);

        // Bounce: two released samples only, then a genuine release.
        clear_events();
        keys[9] = 1'b0;
        repeat (64) step();
        keys[9] = 1'b1;
        repeat (100) step();
        chk("bounce_no_evt", 8'(evt_codes.size()), 8'd0);
        kin_probe("bounce_still_dn", 4'b1011, 4'b0010);
        clear_events();
        keys[9] = 1'b0;
        repeat (130) step();
        chk("release_evt_count", 8'(evt_codes.size()), 8'd1);
        if (evt_codes.size() >= 1) begin
            chk("release_code", {4'h0, evt_codes[0]}, 8'h09);
            chk("release_dn", {7'h0, evt_dns[0]}, 8'h00);
        end

        // Simultaneous rows 0 and 3 on column 1.
        nL = 4'hF;
        clear_events();
        keys[4] = 1'b1;
        keys[7] = 1'b1;
        repeat (170) step();
        chk("simul_evt_count", 8'(evt_codes.size()), 8'd2);
        if (evt_codes.size() >= 2) begin
            chk("simul_first", {4'h0, evt_codes[0]}, 8'h04);
            chk("simul_second", {4'h0, evt_codes[1]}, 8'h07);
            chk("simul_gap", 8'(evt_edges[1] - evt_edges[0]), 8'd32);
        end
        kin_probe("simul_kin", 4'b1101, 4'b1001);

        // Multi-column gating with keys (0,0),(1,0),(1,3),(3,2) down.
        nL = 4'hF;
        clear_events();
        keys[0]  = 1'b1;
        keys[14] = 1'b1;
        repeat (130) step();
        chk("multi_evt_count", 8'(evt_codes.size()), 8'd2);
        kin_tbl[0] = '{nl: 4'b1111, kin: 4'b0000};
        kin_tbl[1] = '{nl: 4'b0110, kin: 4'b0101};
        kin_tbl[2] = '{nl: 4'b1101, kin: 4'b1001};
        kin_tbl[3] = '{nl: 4'b1110, kin: 4'b0001};
        kin_tbl[4] = '{nl: 4'b0111, kin: 4'b0100};
        kin_tbl[5] = '{nl: 4'b0000, kin: 4'b1101};
        kin_tbl[6] = '{nl: 4'b1011, kin: 4'b0000};
        for (int i = 0; i < 7; i++) kin_probe($sformatf("kin_tbl%0d", i), kin_tbl[i].nl,
                                               kin_tbl[i].kin);

        // Reset while key (1,1) is held: cleared, then re-detected.
        nL   = 4'hF;
        keys = '0;
        repeat (130) step();
        keys[5] = 1'b1;
        repeat (130) step();
        kin_probe("held_kin", 4'b1101, 4'b0010);
        apply_reset("held_rst");
        clear_events();
        repeat (130) step();
        chk("redetect_count", 8'(evt_codes.size()), 8'd1);
        if (evt_codes.size() >= 1) begin
            chk("redetect_code", {4'h0, evt_codes[0]}, 8'h05);
            chk("redetect_dn", {7'h0, evt_dns[0]}, 8'h01);
        end

        // Randomised traffic with contact noise against the model.
        noise_en = 1;
        for (int i = 0; i < 3000; i++) begin
            int k;
            if ($urandom_range(63) == 0) begin
                k       = int'($urandom_range(15));
                keys[k] = ~keys[k];
            end
            if ($urandom_range(15) == 0) nL = 4'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
